ms_game_timer: RTL and testbench

Parametrised successor to the minesweeper elapsed-time counter. Adds an internal clock-enable prescaler, runtime up/down direction, wrap-or-saturate end behaviour, pause/resume and a loadable countdown preset. Sits between the game-control FSM (start/stop/pause strobes) and the score/seven-segment display path, which consumes q and the expired pulse.

---
 rtl/ms_pkg.sv | 14 +
 rtl/ms_game_timer_if.sv | 27 ++
 rtl/ms_prescaler.sv | 25 ++
 rtl/ms_game_timer.sv | 126 ++++++++++++
 tb/tb_ms_game_timer.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ms_pkg.sv
// Shared encodings for the game timer: FSM states and count direction.
package ms_pkg;

    typedef enum logic [1:0] {
        MS_T_IDLE  = 2'd0,
        MS_T_RUN   = 2'd1,
        MS_T_PAUSE = 2'd2,
        MS_T_DONE  = 2'd3
    } ms_state_e;

    localparam logic MS_UP   = 1'b0;
    localparam logic MS_DOWN = 1'b1;

endpackage

// File: rtl/ms_game_timer_if.sv
// Control strobes from the game FSM and count/status back to the display path.
interface ms_game_timer_if #(
    parameter int unsigned BIT = 10
);
    logic           start;
    logic           stop;
    logic           pause;
    logic           resume;
    logic           dir;
    logic [BIT-1:0] preset;
    logic [BIT-1:0] q;
    logic           tick;
    logic           running;
    logic           paused;
    logic           done;
    logic           expired;

    modport master (
        output start, stop, pause, resume, dir, preset,
        input  q, tick, running, paused, done, expired
    );

    modport slave (
        input  start, stop, pause, resume, dir, preset,
        output q, tick, running, paused, done, expired
    );
endinterface

// File: rtl/ms_prescaler.sv
// Clock-enable prescaler: counts 0..DIV-1 while enabled, term_c marks the wrap cycle.
module ms_prescaler #(
    parameter int unsigned DIV     = 25000000,
    parameter int unsigned DIV_BIT = 25
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    input  logic sclr,
    output logic term_c
);
    localparam logic [DIV_BIT-1:0] LAST = DIV_BIT'(DIV - 1);

    logic [DIV_BIT-1:0] cnt;

    assign term_c = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (clr || sclr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= term_c ? '0 : cnt + DIV_BIT'(1);
        end
    end
endmodule

// File: rtl/ms_game_timer.sv
// Elapsed/countdown game timer with prescaler, pause/resume and wrap-or-saturate end.
module ms_game_timer
    import ms_pkg::*;
#(
    parameter int unsigned N       = 600,
    parameter int unsigned BIT     = 10,
    parameter int unsigned DIV     = 25000000,
    parameter int unsigned DIV_BIT = 25,
    parameter int unsigned WRAP    = 0
) (
    input  logic            clk,
    input  logic            clr,
    ms_game_timer_if.slave  bus
);
    localparam logic [BIT-1:0] Q_MAX = BIT'(N);

    ms_state_e      state, state_n;
    logic [BIT-1:0] q_r, q_n;
    logic           dir_r, dir_n;
    logic           tick_r, tick_n;
    logic           expired_r, expired_n;
    logic           running_r, paused_r, done_r;
    logic           term_c;
    logic           sclr_c;
    logic [BIT-1:0] preset_c;

    // Restart or stop both rewind the step phase.
    assign sclr_c   = bus.start || bus.stop;
    assign preset_c = (bus.preset > Q_MAX) ? Q_MAX : bus.preset;

    ms_prescaler #(
        .DIV     (DIV),
        .DIV_BIT (DIV_BIT)
    ) u_prescaler (
        .clk    (clk),
        .clr    (clr),
        .en     (running_r),
        .sclr   (sclr_c),
        .term_c (term_c)
    );

    // Next-state: stop > start > pause > resume; a control input discards a coincident step.
    always_comb begin
        state_n   = state;
        q_n       = q_r;
        dir_n     = dir_r;
        tick_n    = 1'b0;
        expired_n = 1'b0;
        if (bus.stop) begin
            state_n = MS_T_IDLE;
        end else if (bus.start) begin
            state_n = MS_T_RUN;
            dir_n   = bus.dir;
            q_n     = (bus.dir == MS_DOWN) ? preset_c : '0;
        end else begin
            unique case (state)
                MS_T_RUN: begin
                    if (bus.pause) begin
                        state_n = MS_T_PAUSE;
                    end else if (term_c) begin
                        if (dir_r == MS_UP) begin
                            if (q_r < Q_MAX) begin
                                q_n    = q_r + BIT'(1);
                                tick_n = 1'b1;
                            end else if (WRAP != 0) begin
                                q_n    = '0;
                                tick_n = 1'b1;
                            end else begin
                                state_n   = MS_T_DONE;
                                expired_n = 1'b1;
                            end
                        end else begin
                            if (q_r != '0) begin
                                q_n    = q_r - BIT'(1);
                                tick_n = 1'b1;
                            end else if (WRAP != 0) begin
                                q_n    = Q_MAX;
                                tick_n = 1'b1;
                            end else begin
                                state_n   = MS_T_DONE;
                                expired_n = 1'b1;
                            end
                        end
                    end
                end
                MS_T_PAUSE: begin
                    if (bus.resume) begin
                        state_n = MS_T_RUN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State register; status flags are registered copies of the next state.
    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= MS_T_IDLE;
            q_r       <= '0;
            dir_r     <= MS_UP;
            tick_r    <= 1'b0;
            expired_r <= 1'b0;
            running_r <= 1'b0;
            paused_r  <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state     <= state_n;
            q_r       <= q_n;
            dir_r     <= dir_n;
            tick_r    <= tick_n;
            expired_r <= expired_n;
            running_r <= (state_n == MS_T_RUN);
            paused_r  <= (state_n == MS_T_PAUSE);
            done_r    <= (state_n == MS_T_DONE);
        end
    end

    assign bus.q       = q_r;
    assign bus.tick    = tick_r;
    assign bus.expired = expired_r;
    assign bus.running = running_r;
    assign bus.paused  = paused_r;
    assign bus.done    = done_r;
endmodule

// File: tb/tb_ms_game_timer.sv
// Two timers (saturate and wrap) on shared stimulus, scoreboarded against a reference model.
module tb_ms_game_timer;
    localparam int N   = 9;
    localparam int DIV = 4;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_DONE  = 3;

    typedef struct packed {
        logic [3:0] q;
        logic       tick;
        logic       running;
        logic       paused;
        logic       done;
        logic       expired;
    } exp_t;

    logic clk;
    logic clr;

    ms_game_timer_if #(.BIT(4)) bus0 ();
    ms_game_timer_if #(.BIT(4)) bus1 ();

    ms_game_timer #(.N(9), .BIT(4), .DIV(4), .DIV_BIT(2), .WRAP(0)) dut0 (
        .clk (clk),
        .clr (clr),
        .bus (bus0)
    );

    ms_game_timer #(.N(9), .BIT(4), .DIV(4), .DIV_BIT(2), .WRAP(1)) dut1 (
        .clk (clk),
        .clr (clr),
        .bus (bus1)
    );

    int n_checks = 0;
    int n_pass   = 0;

    exp_t sb0[$];
    exp_t sb1[$];

    int m_state[2];
    int m_q[2];
    int m_pre[2];
    int m_dir[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference: time advances in whole clocks; a step lands every DIV clocks spent in RUN.
    task automatic model(input int i, input logic c, input logic st, input logic sp,
                         input logic pa, input logic re, input logic d, input int pr);
        exp_t e;
        int   tk;
        int   ex;
        int   nxt_pre;
        bit   step;
        bit   wrap;
        wrap = (i == 1);
        tk   = 0;
        ex   = 0;
        if (c) begin
            m_state[i] = S_IDLE;
            m_q[i]     = 0;
            m_pre[i]   = 0;
            m_dir[i]   = 0;
        end else begin
            step    = (m_state[i] == S_RUN) && (m_pre[i] == DIV - 1);
            nxt_pre = (st || sp) ? 0 : (m_state[i] == S_RUN) ? (m_pre[i] + 1) % DIV : m_pre[i];
            if (sp) begin
                m_state[i] = S_IDLE;
            end else if (st) begin
                m_state[i] = S_RUN;
                m_dir[i]   = int'(d);
                m_q[i]     = d ? ((pr > N) ? N : pr) : 0;
            end else if (m_state[i] == S_RUN) begin
                if (pa) begin
                    m_state[i] = S_PAUSE;
                end else if (step) begin
                    if (m_dir[i] == 0) begin
                        if (m_q[i] < N) begin m_q[i] = m_q[i] + 1; tk = 1; end
                        else if (wrap) begin m_q[i] = 0; tk = 1; end
                        else begin m_state[i] = S_DONE; ex = 1; end
                    end else begin
                        if (m_q[i] > 0) begin m_q[i] = m_q[i] - 1; tk = 1; end
                        else if (wrap) begin m_q[i] = N; tk = 1; end
                        else begin m_state[i] = S_DONE; ex = 1; end
                    end
                end
            end else if (m_state[i] == S_PAUSE && re) begin
                m_state[i] = S_RUN;
            end
            m_pre[i] = nxt_pre;
        end
        e.q       = 4'(m_q[i]);
        e.tick    = (tk != 0);
        e.running = (m_state[i] == S_RUN);
        e.paused  = (m_state[i] == S_PAUSE);
        e.done    = (m_state[i] == S_DONE);
        e.expired = (ex != 0);
        if (i == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endtask

    // One clock of stimulus: drive, predict, then move to the next falling edge.
    task automatic cyc(input logic c, input logic st, input logic sp, input logic pa,
                       input logic re, input logic d, input int pr);
        clr          = c;
        bus0.start   = st;  bus1.start  = st;
        bus0.stop    = sp;  bus1.stop   = sp;
        bus0.pause   = pa;  bus1.pause  = pa;
        bus0.resume  = re;  bus1.resume = re;
        bus0.dir     = d;   bus1.dir    = d;
        bus0.preset  = 4'(pr);
        bus1.preset  = 4'(pr);
        model(0, c, st, sp, pa, re, d, pr);
        model(1, c, st, sp, pa, re, d, pr);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    function automatic string fmt(input exp_t v);
        return $sformatf("q=%0d tick=%0b run=%0b pau=%0b done=%0b exp=%0b",
                         v.q, v.tick, v.running, v.paused, v.done, v.expired);
    endfunction

    task automatic sb_cmp(input string name, input exp_t act, input exp_t exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %s expected %s at %0t", name, fmt(act), fmt(exp), $time);
    endtask

    // Monitor: every clock the timers present a fresh output word.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(posedge clk);
            #1;
            if (sb0.size() > 0) begin
                e = sb0.pop_front();
                a = '{bus0.q, bus0.tick, bus0.running, bus0.paused, bus0.done, bus0.expired};
                sb_cmp("sb_sat", a, e);
            end
            if (sb1.size() > 0) begin
                e = sb1.pop_front();
                a = '{bus1.q, bus1.tick, bus1.running, bus1.paused, bus1.done, bus1.expired};
                sb_cmp("sb_wrap", a, e);
            end
        end
    end

    initial begin
        // Count up to terminal, saturate vs wrap
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("reset_q", int'(bus0.q), 0);
        chk("reset_running", int'(bus0.running), 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        idle(4);
        chk("first_step_q", int'(bus0.q), 1);
        idle(32);
        chk("q_at_36", int'(bus0.q), 9);
        chk("not_done_at_36", int'(bus0.done), 0);
        idle(4);
        chk("sat_done", int'(bus0.done), 1);
        chk("sat_expired", int'(bus0.expired), 1);
        chk("sat_q_held", int'(bus0.q), 9);
        chk("sat_no_tick", int'(bus0.tick), 0);
        chk("wrap_q0", int'(bus1.q), 0);
        chk("wrap_tick", int'(bus1.tick), 1);
        chk("wrap_running", int'(bus1.running), 1);
        idle(1);
        chk("expired_single", int'(bus0.expired), 0);
        chk("wrap_never_expired", int'(bus1.expired), 0);

        // Countdown and preset clamp
        cyc(0, 1, 0, 0, 0, 1, 3);
        chk("down_load", int'(bus0.q), 3);
        idle(12);
        chk("down_zero", int'(bus0.q), 0);
        idle(4);
        chk("down_done", int'(bus0.done), 1);
        chk("down_expired", int'(bus0.expired), 1);
        cyc(0, 1, 0, 0, 0, 1, 15);
        chk("preset_clamp", int'(bus0.q), 9);

        // Pause two clocks after the q=2 step
        cyc(0, 1, 0, 0, 0, 0, 0);
        idle(9);
        cyc(0, 0, 0, 1, 0, 0, 0);
        idle(10);
        chk("pause_q", int'(bus0.q), 2);
        chk("pause_flag", int'(bus0.paused), 1);
        chk("pause_no_tick", int'(bus0.tick), 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        idle(1);
        chk("resume_plus1", int'(bus0.q), 2);
        idle(1);
        chk("resume_plus2", int'(bus0.q), 3);
        chk("resume_tick", int'(bus0.tick), 1);

        // Start+stop together: stop wins
        cyc(0, 1, 0, 0, 0, 0, 0);
        idle(20);
        chk("before_stop_q", int'(bus0.q), 5);
        cyc(0, 1, 1, 0, 0, 0, 0);
        chk("stop_wins_q", int'(bus0.q), 5);
        chk("stop_wins_idle", int'(bus0.running), 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        idle(3);
        chk("restart_q0", int'(bus0.q), 0);
        idle(1);
        chk("restart_step", int'(bus0.q), 1);

        // clr overrides start, and clears DONE
        idle(5);
        cyc(1, 1, 0, 0, 0, 0, 0);
        chk("clr_q", int'(bus0.q), 0);
        chk("clr_running", int'(bus0.running), 0);
        cyc(0, 1, 0, 0, 0, 1, 0);
        idle(4);
        chk("preset0_done", int'(bus0.done), 1);
        chk("preset0_wrap_q", int'(bus1.q), 9);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("clr_done_q", int'(bus0.q), 0);
        chk("clr_done_flag", int'(bus0.done), 0);

        // Randomised traffic
        repeat (2500) begin
            cyc($urandom_range(63) == 0, $urandom_range(15) == 0, $urandom_range(31) == 0,
                $urandom_range(15) == 0, $urandom_range(7) == 0, 1'($urandom_range(1)),
                int'($urandom_range(15)));
        end

        #20;
        chk("sb_drained", sb0.size() + sb1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
